imem_loader: RTL and testbench

Host-side writer for the pattern processor's instruction-buffer write port. Accepts a byte stream over a valid/ready handshake, parses a 4-byte header (start address, word count), and assembles payload bytes into full instruction-buffer words. Each completed word is issued as a single-cycle `imem_write` strobe with `imem_write_adr` / `imem_in`. Sits between the external load interface and the `imem_*` inputs of the processor top, and holds the processor in reset while loading.

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: parses a header + payload byte stream into instruction-buffer word writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int d_width = 8,
    parameter int i_adr_width = 10,
    parameter int i_width = 20,
    parameter int i_buffer_size = 2,
    parameter int cnt_width = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [d_width-1:0]                load_data,
    input  logic                              load_valid,
    output logic                              load_ready,
    output logic [i_adr_width-1:0]            imem_write_adr,
    output logic                              imem_write,
    output logic [i_buffer_size*i_width-1:0]  imem_in,
    output logic                              pat_hold,
    output logic                              done,
    output logic                              error
);
    localparam int w = i_buffer_size * i_width;
    localparam int b = (w + d_width - 1) / d_width;
    localparam int bw = (b > 1) ? $clog2(b) : 1;

    typedef enum logic [2:0] {
        ADR_LO, ADR_HI, CNT_LO, CNT_HI, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t fin = CHECK;
    logic [d_width-1:0] csum;
`else
    localparam state_t fin = DONE;
`endif

    state_t state, state_next;
    logic [i_adr_width-1:0] adr;
    logic [cnt_width-1:0] cnt;
    logic [bw-1:0] bidx;
    logic [b*d_width-1:0] wbuf, wfill;
    logic accept, last;

    assign accept = load_valid && load_ready;
    assign last = bidx == bw'(b - 1);

    always_ff @(posedge clk)
        if (reset) state <= ADR_LO;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            ADR_LO:  if (accept) state_next = ADR_HI;
            ADR_HI:  if (accept) state_next = CNT_LO;
            CNT_LO:  if (accept) state_next = CNT_HI;
            CNT_HI:  if (accept) state_next = ({load_data, cnt[d_width-1:0]} == '0) ? fin : DATA;
            DATA:    if (accept && last) state_next = WRITE;
            WRITE:   state_next = (cnt == cnt_width'(1)) ? fin : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   if (accept) state_next = DONE;
`endif
            DONE:    state_next = ADR_LO;
            default: state_next = ADR_LO;
        endcase
    end

    always_comb begin
        load_ready = state != WRITE && state != DONE;
        imem_write = state == WRITE;
        done = state == DONE;
        pat_hold = state != ADR_LO && state != DONE;
    end

    // Current byte merged into the partial word, so the last byte can be written out directly.
    always_comb begin
        wfill = wbuf;
        wfill[bidx*d_width +: d_width] = load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adr <= '0;
            cnt <= '0;
            bidx <= '0;
            wbuf <= '0;
            error <= 1'b0;
            imem_write_adr <= '0;
            imem_in <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            if (accept && state == ADR_LO) begin
                adr <= i_adr_width'(load_data);
                error <= 1'b0;
            end
            if (accept && state == ADR_HI) adr <= i_adr_width'({load_data, adr[d_width-1:0]});
            if (accept && state == CNT_LO) cnt <= cnt_width'(load_data);
            if (accept && state == CNT_HI) begin
                cnt <= cnt_width'({load_data, cnt[d_width-1:0]});
                bidx <= '0;
            end
            if (accept && state == DATA) begin
                wbuf <= wfill;
                bidx <= last ? '0 : bidx + 1'b1;
                if (last) begin
                    imem_in <= wfill[w-1:0];
                    imem_write_adr <= adr;
                end
            end
            if (state == WRITE) begin
                adr <= adr + 1'b1;
                cnt <= cnt - 1'b1;
                if (&adr) error <= 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) csum <= (state == ADR_LO) ? load_data : csum ^ load_data;
            if (accept && state == CHECK && load_data != csum) error <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader (default build; checksum path under IMEM_LOADER_CHECKSUM_EN).
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] load_data = '0;
    logic load_valid = 1'b0;
    logic load_ready, imem_write, pat_hold, done, error;
    logic [9:0] imem_write_adr;
    logic [39:0] imem_in;

    imem_loader dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .imem_write_adr(imem_write_adr), .imem_write(imem_write),
        .imem_in(imem_in), .pat_hold(pat_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] a;
        logic [39:0] d;
        int t;
    } wr_t;
    wr_t wq[$];
    wr_t mon_e;
    int cyc = 0;
    int done_cnt = 0;
    int rdy_bad = 0;
    int vecs = 0;
    int miss = 0;
    logic [7:0] ck;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_write === 1'b1) begin
            mon_e.a = imem_write_adr;
            mon_e.d = imem_in;
            mon_e.t = cyc;
            wq.push_back(mon_e);
        end
        if (done === 1'b1) done_cnt++;
        if (!reset && load_ready !== !(imem_write || done)) rdy_bad++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int gap = 0);
        int n = 0;
        idle(gap);
        load_data = d;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            miss++;
            $display("FAIL send_timeout: load_ready stuck at %b, required 1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
        ck ^= d;
    endtask

    task automatic header(input logic [15:0] a, input logic [15:0] n);
        ck = 8'h00;
        send(a[7:0]); send(a[15:8]); send(n[7:0]); send(n[15:8]);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(ck);
`endif
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        vecs++; if (load_ready !== 1'b1) begin miss++; $display("FAIL rst_ready: got %b want 1", load_ready); end
        vecs++; if ({imem_write, done, error, pat_hold} !== 4'b0000) begin miss++; $display("FAIL rst_flags: got %b want 0000", {imem_write, done, error, pat_hold}); end
        vecs++; if (imem_write_adr !== 10'h000) begin miss++; $display("FAIL rst_adr: got %h want 000", imem_write_adr); end
        vecs++; if (imem_in !== 40'h0) begin miss++; $display("FAIL rst_data: got %h want 0", imem_in); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        clear_mon();
        header(16'h0010, 16'h0001);
        vecs++; if (pat_hold !== 1'b1) begin miss++; $display("FAIL single_hold: got %b want 1", pat_hold); end
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        finish_load();
        idle(4);
        vecs++; if (wq.size() !== 1) begin miss++; $display("FAIL single_cnt: got %0d writes want 1", wq.size()); end
        if (wq.size() > 0) begin
            vecs++; if (wq[0].a !== 10'h010) begin miss++; $display("FAIL single_adr: got %h want 010", wq[0].a); end
            vecs++; if (wq[0].d !== 40'h5544332211) begin miss++; $display("FAIL single_data: got %h want 5544332211", wq[0].d); end
        end
        vecs++; if (done_cnt !== 1) begin miss++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
        vecs++; if (error !== 1'b0) begin miss++; $display("FAIL single_err: got %b want 0", error); end
        vecs++; if (pat_hold !== 1'b0) begin miss++; $display("FAIL single_hold_end: got %b want 0", pat_hold); end
    endtask

    task automatic test_wrap();
        logic [39:0] exp_d[3] = '{40'h0504030201, 40'h0A09080706, 40'h0F0E0D0C0B};
        logic [9:0] exp_a[3] = '{10'h3FE, 10'h3FF, 10'h000};
        clear_mon();
        header(16'h03FE, 16'h0003);
        for (int i = 1; i <= 15; i++) send(8'(i));
        finish_load();
        idle(4);
        vecs++; if (wq.size() !== 3) begin miss++; $display("FAIL wrap_cnt: got %0d writes want 3", wq.size()); end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            vecs++; if (wq[i].a !== exp_a[i]) begin miss++; $display("FAIL wrap_adr%0d: got %h want %h", i, wq[i].a, exp_a[i]); end
            vecs++; if (wq[i].d !== exp_d[i]) begin miss++; $display("FAIL wrap_data%0d: got %h want %h", i, wq[i].d, exp_d[i]); end
            if (i > 0) begin
                vecs++; if (wq[i].t - wq[i-1].t !== 6) begin miss++; $display("FAIL wrap_gap%0d: got %0d cycles want 6", i, wq[i].t - wq[i-1].t); end
            end
        end
        vecs++; if (error !== 1'b1) begin miss++; $display("FAIL wrap_err: got %b want 1", error); end
        vecs++; if (done_cnt !== 1) begin miss++; $display("FAIL wrap_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_zero_count();
        clear_mon();
        header(16'h0020, 16'h0000);
        finish_load();
        vecs++; if (done !== 1'b1) begin miss++; $display("FAIL zero_done: got %b want 1", done); end
        vecs++; if (pat_hold !== 1'b0) begin miss++; $display("FAIL zero_hold: got %b want 0", pat_hold); end
        vecs++; if (error !== 1'b0) begin miss++; $display("FAIL zero_err_clear: got %b want 0", error); end
        idle(3);
        vecs++; if (wq.size() !== 0) begin miss++; $display("FAIL zero_writes: got %0d want 0", wq.size()); end
    endtask

    task automatic test_gaps();
        clear_mon();
        header(16'h0100, 16'h0001);
        send(8'hA1, 0); send(8'hB2, 3); send(8'hC3, 1); send(8'hD4, 2); send(8'hE5, 4);
        finish_load();
        idle(4);
        vecs++; if (wq.size() !== 1) begin miss++; $display("FAIL gaps_cnt: got %0d writes want 1", wq.size()); end
        if (wq.size() > 0) begin
            vecs++; if (wq[0].a !== 10'h100) begin miss++; $display("FAIL gaps_adr: got %h want 100", wq[0].a); end
            vecs++; if (wq[0].d !== 40'hE5D4C3B2A1) begin miss++; $display("FAIL gaps_data: got %h want E5D4C3B2A1", wq[0].d); end
        end
        vecs++; if (rdy_bad !== 0) begin miss++; $display("FAIL ready_timing: got %0d bad cycles want 0", rdy_bad); end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        header(16'h0040, 16'h0001);
        send(8'h99); send(8'h88); send(8'h77);
        reset = 1'b1;
        idle(1);
        vecs++; if ({load_ready, imem_write, done, error, pat_hold} !== 5'b10000) begin miss++; $display("FAIL mrst_flags: got %b want 10000", {load_ready, imem_write, done, error, pat_hold}); end
        vecs++; if ({imem_write_adr, imem_in} !== 50'h0) begin miss++; $display("FAIL mrst_regs: got %h/%h want 0/0", imem_write_adr, imem_in); end
        reset = 1'b0;
        idle(1);
        vecs++; if (wq.size() !== 0) begin miss++; $display("FAIL mrst_nowrite: got %0d writes want 0", wq.size()); end
        header(16'h0040, 16'h0001);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        finish_load();
        idle(4);
        vecs++; if (wq.size() !== 1) begin miss++; $display("FAIL mrst_reload_cnt: got %0d writes want 1", wq.size()); end
        if (wq.size() > 0) begin
            vecs++; if (wq[0].a !== 10'h040 || wq[0].d !== 40'h0504030201) begin miss++; $display("FAIL mrst_reload: got %h/%h want 040/0504030201", wq[0].a, wq[0].d); end
        end
        vecs++; if (done_cnt !== 1) begin miss++; $display("FAIL mrst_done: got %0d pulses want 1", done_cnt); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_mon();
        header(16'h0005, 16'h0000);
        send(8'h00);
        vecs++; if (done !== 1'b1 || error !== 1'b1) begin miss++; $display("FAIL ck_bad: got done=%b err=%b want 1/1", done, error); end
        header(16'h0005, 16'h0000);
        send(8'h05);
        vecs++; if (done !== 1'b1 || error !== 1'b0) begin miss++; $display("FAIL ck_good: got done=%b err=%b want 1/0", done, error); end
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_zero_count();
        test_gaps();
        test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
